// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: deframes start/data/parity/stop and pushes good words to the UFIFO.
// Events are registered single-cycle pulses in the DONE cycle, one clock after the last stop sample; no backpressure (a full UFIFO drops the word and flags overrun).
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic                  rx_i,
  input  logic                  ufifo_full_i,
  output logic                  ufifo_wr_o,
  output logic [DATA_WIDTH-1:0] ufifo_data_o,
  output logic                  rx_done_o,
  output logic                  parity_err_o,
  output logic                  bad_frame_o,
  output logic                  overrun_o,
  output logic                  rx_busy_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, STOP2, DONE, WAIT_IDLE
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_q, rx_s;
  logic [DIV_WIDTH-1:0]  div_cnt, cfg_div;
  logic [3:0]            os_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  cfg_par_en, cfg_odd, cfg_stop2, par_err;
  logic                  tick, samp, frame_go, done_set, bad_set;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= rx_i;
      rx_s <= rx_q;
    end
  end

  // START samples on the 8th tick (mid start bit); every later field is 16 ticks on.
  assign tick     = (div_cnt == cfg_div);
  assign samp     = tick && (os_cnt == ((state == START) ? 4'd7 : 4'd15));
  assign frame_go = (state == IDLE) && rx_en_i && !rx_s;

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    bad_set   = 1'b0;
    case (state)
      IDLE:      if (frame_go) state_nxt = START;
      START:     if (samp) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (samp && (bit_cnt == CW'(DATA_WIDTH - 1)))
                   state_nxt = cfg_par_en ? PARITY : STOP;
      PARITY:    if (samp) state_nxt = STOP;
      STOP: begin
        if (samp) begin
          if (!rx_s) begin
            state_nxt = WAIT_IDLE;
            bad_set   = 1'b1;
          end else if (cfg_stop2) begin
            state_nxt = STOP2;
          end else begin
            state_nxt = DONE;
            done_set  = 1'b1;
          end
        end
      end
      STOP2: begin
        if (samp) begin
          if (!rx_s) begin
            state_nxt = WAIT_IDLE;
            bad_set   = 1'b1;
          end else begin
            state_nxt = DONE;
            done_set  = 1'b1;
          end
        end
      end
      DONE:      state_nxt = IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (!rx_en_i) begin
      state_nxt = IDLE;
      done_set  = 1'b0;
      bad_set   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Counters sit at zero through IDLE so the first tick lands D+1 clocks after the start edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (!rx_en_i || (state == IDLE)) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      os_cnt  <= samp ? 4'd0 : os_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_div    <= '0;
      cfg_par_en <= 1'b0;
      cfg_odd    <= 1'b0;
      cfg_stop2  <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_err    <= 1'b0;
    end else begin
      if (frame_go) begin
        cfg_div    <= baud_div_i;
        cfg_par_en <= parity_en_i;
        cfg_odd    <= parity_odd_i;
        cfg_stop2  <= stop2_i;
        bit_cnt    <= '0;
        par_err    <= 1'b0;
      end
      if ((state == DATA) && samp && rx_en_i) begin
        shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + CW'(1);
      end
      if ((state == PARITY) && samp && rx_en_i)
        par_err <= (^shift) ^ rx_s ^ cfg_odd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ufifo_wr_o   <= 1'b0;
      ufifo_data_o <= '0;
      rx_done_o    <= 1'b0;
      parity_err_o <= 1'b0;
      bad_frame_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      ufifo_wr_o   <= done_set && !ufifo_full_i;
      overrun_o    <= done_set && ufifo_full_i;
      rx_done_o    <= done_set;
      parity_err_o <= done_set && par_err;
      bad_frame_o  <= bad_set;
      if (done_set && !ufifo_full_i) ufifo_data_o <= shift;
    end
  end

  assign rx_busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are built bit by bit and the expected event per frame
// (kind, data, cycle of the DONE/bad-frame pulse) comes from frame arithmetic.
module tb_uart_rx;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n, rx_en, parity_en, parity_odd, stop2, rx, ufifo_full;
  logic [15:0] baud_div;
  logic        ufifo_wr, rx_done, parity_err, bad_frame, overrun, rx_busy;
  logic [7:0]  ufifo_data;

  uart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_en_i(rx_en), .baud_div_i(baud_div),
    .parity_en_i(parity_en), .parity_odd_i(parity_odd), .stop2_i(stop2),
    .rx_i(rx), .ufifo_full_i(ufifo_full), .ufifo_wr_o(ufifo_wr),
    .ufifo_data_o(ufifo_data), .rx_done_o(rx_done), .parity_err_o(parity_err),
    .bad_frame_o(bad_frame), .overrun_o(overrun), .rx_busy_o(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic       wr, done, perr, bf, ovr;
    logic [7:0] dat;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t o;
    if (rx_busy) busy_cnt = busy_cnt + 1;
    if (ufifo_wr || rx_done || parity_err || bad_frame || overrun) begin
      o.t = cyc; o.wr = ufifo_wr; o.done = rx_done; o.perr = parity_err;
      o.bf = bad_frame; o.ovr = overrun; o.dat = ufifo_data;
      obs_q.push_back(o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_events(input string tag);
    ev_t o, e;
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ".time"}, ((o.t >= e.t - 1) && (o.t <= e.t + 1)) ? e.t : o.t, e.t);
      chk({tag, ".wr"}, o.wr, e.wr);
      chk({tag, ".done"}, o.done, e.done);
      chk({tag, ".perr"}, o.perr, e.perr);
      chk({tag, ".bad_frame"}, o.bf, e.bf);
      chk({tag, ".overrun"}, o.ovr, e.ovr);
      if (e.wr) chk({tag, ".data"}, o.dat, e.dat);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // sb: 0 good stops, 1 first stop low, 2 second stop low. tail: extra low bit periods after the frame.
  task automatic send_frame(input logic [7:0] d, input int dv, input bit pe, input bit odd,
                            input bit s2, input bit flip, input int sb, input bit full,
                            input int tail);
    int  b, l1, tf, lstop;
    bit  par;
    bit  bits[$];
    ev_t e;
    b = 16 * (dv + 1);
    if (!s2 && sb == 2) sb = 0;
    par = (^d) ^ odd ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par);
    bits.push_back(sb != 1);
    if (s2) bits.push_back(sb != 2);
    l1 = 8 * (dv + 1) + (DW + (pe ? 1 : 0) + 1) * b;
    lstop = (sb == 1) ? l1 : ((s2) ? l1 + b : l1);
    baud_div = dv[15:0]; parity_en = pe; parity_odd = odd; stop2 = s2; ufifo_full = full;
    tf = 0;
    for (int i = 0; i < bits.size(); i++) begin
      rx = bits[i];
      if (i == 0) tf = cyc;
      if (i == 1) begin
        baud_div   = 16'($urandom_range(0, 7));
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        stop2      = 1'($urandom);
      end
      cycles(b);
    end
    if (tail > 0) begin
      rx = 1'b0;
      cycles(tail * b);
      chk("break_busy", rx_busy, 1);
    end
    rx = 1'b1;
    e.t = tf + 3 + lstop;
    e.bf = (sb != 0);
    e.done = (sb == 0);
    e.wr = (sb == 0) && !full;
    e.ovr = (sb == 0) && full;
    e.perr = (sb == 0) && pe && flip;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int b0;
    rst_n = 1'b0; rx = 1'b1; rx_en = 1'b1; baud_div = 16'd0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; ufifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", ufifo_wr, 0);
    chk("rst_data", ufifo_data, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_bad", bad_frame, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    cycles(5);

    send_frame(8'hA5, 0, 0, 0, 0, 0, 0, 0, 0);  check_events("a5_8n1");
    send_frame(8'h03, 0, 1, 0, 0, 1, 0, 0, 0);  check_events("even_bad");
    send_frame(8'h03, 0, 1, 0, 0, 0, 0, 0, 0);  check_events("even_ok");
    send_frame(8'h03, 0, 1, 1, 0, 0, 0, 0, 0);  check_events("odd_ok");
    send_frame(8'h03, 0, 1, 1, 0, 1, 0, 0, 0);  check_events("odd_bad");

    send_frame(8'h81, 0, 0, 0, 0, 0, 1, 0, 40);
    cycles(4);
    chk("break_idle", rx_busy, 0);
    check_events("break");
    send_frame(8'h5A, 0, 0, 0, 0, 0, 0, 0, 0);  check_events("after_break");

    baud_div = 16'd0;
    cycles(10);
    b0 = busy_cnt;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(40);
    chk("glitch_busy_cycles", busy_cnt - b0, 8);
    check_events("glitch");

    send_frame(8'h11, 0, 0, 0, 0, 0, 0, 1, 0);  check_events("overrun");
    chk("data_hold", ufifo_data, 8'h5A);
    send_frame(8'h22, 0, 0, 0, 0, 0, 0, 0, 0);  check_events("after_ovr");

    send_frame(8'h00, 3, 1, 1, 1, 0, 0, 0, 0);  check_events("8o2_00");
    send_frame(8'hFF, 3, 1, 1, 1, 0, 0, 0, 0);  check_events("8o2_ff");
    baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    rx = 1'b0;
    cycles(3 * 64);
    rx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", rx_busy, 0);
    cycles(3 * 64);
    rx = 1'b1;
    cycles(20);
    rx_en = 1'b1;
    cycles(20);
    check_events("abort");

    baud_div = 16'd1;
    rx = 1'b0;
    cycles(3 * 32);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", rx_busy, 0);
    cycles(3);
    rst_n = 1'b1;
    rx = 1'b1;
    cycles(20);
    check_events("midrst");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      int dv, sb, r;
      bit pe, odd, s2, flip, full;
      d = 8'($urandom);
      dv = $urandom_range(0, 2);
      pe = 1'($urandom); odd = 1'($urandom); s2 = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      full = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 7);
      sb = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      send_frame(d, dv, pe, odd, s2, flip, sb, full, 0);
      check_events("rand");
      cycles((sb != 0) ? 16 * (dv + 1) : $urandom_range(0, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
